// File: rtl/seg7_scan_driver_if.sv
// Display-side bus for seg7_scan_driver: value/dp/enable in, segment/digit drive and frame pulse out.
interface seg7_scan_driver_if;
  logic        en;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  modport master (output en, bcd_in, dp_in, input seg, dig, frame_done);
  modport slave  (input en, bcd_in, dp_in, output seg, dig, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment scanner with per-slot blanking, leading-zero suppression
// and a once-per-frame snapshot of the BCD value so the display never tears.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV    = 12500,
  parameter int unsigned BLANK_CYC   = 16,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus
);

  localparam int unsigned DIV_W   = $clog2(SCAN_DIV);
  localparam logic [7:0]  SEG_OFF = {8{SEG_ACT_LOW}};
  localparam logic [3:0]  DIG_OFF = {4{DIG_ACT_LOW}};

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_bcd_q, shadow_bcd_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       dig_q, dig_d;
  logic             frame_done_q, frame_done_d;

  logic             wrap_c;
  logic             blank_c;
  logic [3:0]       nib_c;
  logic [6:0]       glyph_c;
  logic [3:0]       sup_c;

  assign wrap_c  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign blank_c = (div_q < DIV_W'(BLANK_CYC));
  assign nib_c   = shadow_bcd_q[{idx_q, 2'b00} +: 4];

  // Active-high glyph for the current nibble; non-BCD codes show a dash.
  always_comb begin
    glyph_c = 7'h40;
    case (nib_c)
      4'd0: glyph_c = 7'h3F;
      4'd1: glyph_c = 7'h06;
      4'd2: glyph_c = 7'h5B;
      4'd3: glyph_c = 7'h4F;
      4'd4: glyph_c = 7'h66;
      4'd5: glyph_c = 7'h6D;
      4'd6: glyph_c = 7'h7D;
      4'd7: glyph_c = 7'h07;
      4'd8: glyph_c = 7'h7F;
      4'd9: glyph_c = 7'h6F;
      default: glyph_c = 7'h40;
    endcase
  end

  // A digit is a leading zero when it and every higher nibble are zero; a lit dp keeps it visible.
  always_comb begin
    sup_c = 4'b0000;
    if (BLANK_LZ) begin
      sup_c[1] = (shadow_bcd_q[15:4]  == 12'h000) && !shadow_dp_q[1];
      sup_c[2] = (shadow_bcd_q[15:8]  == 8'h00)   && !shadow_dp_q[2];
      sup_c[3] = (shadow_bcd_q[15:12] == 4'h0)    && !shadow_dp_q[3];
    end
  end

  always_comb begin
    div_d        = div_q;
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    seg_d        = SEG_OFF;
    dig_d        = DIG_OFF;
    frame_done_d = 1'b0;

    if (!bus.en) begin
      // Parked: follow the inputs so re-enable starts from the live value at digit 0.
      div_d        = '0;
      idx_d        = '0;
      shadow_bcd_d = bus.bcd_in;
      shadow_dp_d  = bus.dp_in;
    end else begin
      if (wrap_c) begin
        div_d = '0;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          shadow_bcd_d = bus.bcd_in;
          shadow_dp_d  = bus.dp_in;
          frame_done_d = 1'b1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end

      if (!blank_c && !sup_c[idx_q]) begin
        seg_d = {shadow_dp_q[idx_q], glyph_c} ^ SEG_OFF;
        dig_d = (4'b0001 << idx_q) ^ DIG_OFF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig        = dig_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with an 8-cycle slot and 2-cycle blanking gap.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .SEG_ACT_LOW(1'b1),
    .DIG_ACT_LOW(1'b1),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Park with en=0 so the shadow captures the value, then enable; the next edge is slot position 0.
  task automatic start(input logic [15:0] v, input logic [3:0] d);
    bus.en     = 1'b0;
    bus.bcd_in = v;
    bus.dp_in  = d;
    tick();
    tick();
    bus.en = 1'b1;
  endtask

  // Expected {dig, seg} for scan position p; segs packs active-low glyphs {d3,d2,d1,d0}.
  function automatic logic [11:0] exp_out(input int p, input logic [31:0] segs, input logic [3:0] act);
    int slot;
    int ph;
    slot = (p / SCAN_DIV) % 4;
    ph   = p % SCAN_DIV;
    if (ph < BLANK_CYC || !act[slot]) return {4'hF, 8'hFF};
    return {4'(~(4'b0001 << slot)), segs[slot*8 +: 8]};
  endfunction

  task automatic test_reset;
    logic [11:0] e;
    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.bcd_in = 16'h1234;
    bus.dp_in  = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_por cyc=%0d: dig/seg/fd got %h/%h/%b expected f/ff/0", i, bus.dig, bus.seg, bus.frame_done);
      end
    end
    rst_n = 1'b1;
    start(16'h1234, 4'h0);
    for (int k = 1; k <= 12; k++) tick();
    e = exp_out(11, 32'hF9A4B099, 4'hF);
    vectors++;
    if ({bus.dig, bus.seg} !== e) begin
      miscompares++;
      $display("FAIL reset_pre_lit: dig/seg got %h/%h expected %h/%h", bus.dig, bus.seg, e[11:8], e[7:0]);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_mid cyc=%0d: dig/seg/fd got %h/%h/%b expected f/ff/0", i, bus.dig, bus.seg, bus.frame_done);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_scan;
    logic [11:0] e;
    logic        efd;
    start(16'h1234, 4'h0);
    for (int k = 1; k <= 2 * FRAME; k++) begin
      tick();
      e   = exp_out(k - 1, 32'hF9A4B099, 4'hF);
      efd = (k % FRAME == 0);
      vectors++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {e, efd}) begin
        miscompares++;
        $display("FAIL basic_scan k=%0d: dig/seg/fd got %h/%h/%b expected %h/%h/%b",
                 k, bus.dig, bus.seg, bus.frame_done, e[11:8], e[7:0], efd);
      end
    end
  endtask

  task automatic test_leading_zero;
    logic [15:0] v[3];
    logic [3:0]  d[3];
    logic [31:0] s[3];
    logic [3:0]  a[3];
    logic [11:0] e;
    logic        efd;
    v = '{16'h0007, 16'h0000, 16'h0000};
    d = '{4'b0000, 4'b0000, 4'b0100};
    s = '{32'hFFFFFFF8, 32'hFFFFFFC0, 32'hFF40FFC0};
    a = '{4'b0001, 4'b0001, 4'b0101};
    for (int c = 0; c < 3; c++) begin
      start(v[c], d[c]);
      for (int k = 1; k <= FRAME; k++) begin
        tick();
        e   = exp_out(k - 1, s[c], a[c]);
        efd = (k % FRAME == 0);
        vectors++;
        if ({bus.dig, bus.seg, bus.frame_done} !== {e, efd}) begin
          miscompares++;
          $display("FAIL leading_zero case=%0d k=%0d: dig/seg/fd got %h/%h/%b expected %h/%h/%b",
                   c, k, bus.dig, bus.seg, bus.frame_done, e[11:8], e[7:0], efd);
        end
      end
    end
  endtask

  task automatic test_tearing;
    logic [11:0] e;
    logic        efd;
    start(16'h0099, 4'h0);
    for (int k = 1; k <= 2 * FRAME; k++) begin
      tick();
      if ((k - 1) / FRAME == 0) e = exp_out(k - 1, 32'hFFFF9090, 4'b0011);
      else                      e = exp_out(k - 1, 32'hFFF9C0C0, 4'b0111);
      efd = (k % FRAME == 0);
      vectors++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {e, efd}) begin
        miscompares++;
        $display("FAIL tearing k=%0d: dig/seg/fd got %h/%h/%b expected %h/%h/%b",
                 k, bus.dig, bus.seg, bus.frame_done, e[11:8], e[7:0], efd);
      end
      if (k == 12) bus.bcd_in = 16'h0100;
    end
  endtask

  task automatic test_invalid_nibble;
    logic [11:0] e;
    logic        efd;
    start(16'h00A5, 4'h0);
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      e   = exp_out(k - 1, 32'hFFFFBF92, 4'b0011);
      efd = (k % FRAME == 0);
      vectors++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {e, efd}) begin
        miscompares++;
        $display("FAIL invalid_nibble k=%0d: dig/seg/fd got %h/%h/%b expected %h/%h/%b",
                 k, bus.dig, bus.seg, bus.frame_done, e[11:8], e[7:0], efd);
      end
    end
  endtask

  task automatic test_enable;
    logic [11:0] e;
    logic        efd;
    start(16'h1234, 4'h0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = exp_out(k - 1, 32'hF9A4B099, 4'hF);
      vectors++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {e, 1'b0}) begin
        miscompares++;
        $display("FAIL enable_pre k=%0d: dig/seg/fd got %h/%h/%b expected %h/%h/0",
                 k, bus.dig, bus.seg, bus.frame_done, e[11:8], e[7:0]);
      end
    end
    bus.en     = 1'b0;
    bus.bcd_in = 16'h5678;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
        miscompares++;
        $display("FAIL enable_off cyc=%0d: dig/seg/fd got %h/%h/%b expected f/ff/0", i, bus.dig, bus.seg, bus.frame_done);
      end
    end
    bus.en = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      e   = exp_out(k - 1, 32'h9282F880, 4'hF);
      efd = (k % FRAME == 0);
      vectors++;
      if ({bus.dig, bus.seg, bus.frame_done} !== {e, efd}) begin
        miscompares++;
        $display("FAIL enable_resume k=%0d: dig/seg/fd got %h/%h/%b expected %h/%h/%b",
                 k, bus.dig, bus.seg, bus.frame_done, e[11:8], e[7:0], efd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_leading_zero();
    test_tearing();
    test_invalid_nibble();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
